// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Also reports the number of significant decimal digits in the result.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            ndigits
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [BIN_W-1:0]         shift_q, shift_d;
  logic [BCD_W-1:0]         scratch_q, scratch_d, adjusted;
  logic [BCD_W+BIN_W-1:0]   combined;
  logic [BCD_W-1:0]         bcd_q;
  logic [3:0]               ndig_q, ndig_d;
  logic                     accept, last_step;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        accept  = start;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add-3 on every digit >= 5, then shift left 1.
  always_comb begin
    adjusted = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adjusted[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                          : scratch_q[4*k +: 4];
    end
    combined  = {adjusted, shift_q} << 1;
    scratch_d = combined[BCD_W+BIN_W-1:BIN_W];
    shift_d   = combined[BIN_W-1:0];
  end

  always_comb begin
    ndig_d = 4'd1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_d[4*k +: 4] != 4'd0) ndig_d = 4'(k + 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ndig_q  <= 4'd1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(BIN_W - 1);
      end else if (state_q == SHIFT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (last_step) begin
        bcd_q  <= scratch_d;
        ndig_q <= ndig_d;
      end
    end
  end

  // NOTE: the working registers carry no reset; they are always loaded on
  // acceptance before use and never reach the outputs directly.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q   <= bin_in;
      scratch_q <= '0;
    end else if (state_q == SHIFT) begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_q;
  assign ndigits = ndig_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus random
// values checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [39:0] bcd_out;
  logic [3:0]  ndigits;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [39:0] ref_bcd(input longint unsigned v);
    logic [39:0] r = '0;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_ndig(input longint unsigned v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return 4'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [31:0] v);
    bin_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    bin_in = $urandom;
  endtask

  // Advance until done, counting edges and busy cycles; outputs must hold.
  task automatic wait_done(output int edges, output int busy_cnt, output bit stable);
    logic [39:0] hold;
    hold     = bcd_out;
    edges    = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_out !== hold) stable = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] v);
    int edges, busy_cnt;
    bit stable;
    start_conv(v);
    wait_done(edges, busy_cnt, stable);
    check({tag, "_latency"}, edges, 32);
    check({tag, "_busy_cycles"}, busy_cnt, 32);
    check({tag, "_hold"}, stable, 1);
    check({tag, "_bcd"}, bcd_out, ref_bcd(v));
    check({tag, "_ndig"}, ndigits, ref_ndig(v));
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_bcd_kept"}, bcd_out, ref_bcd(v));
  endtask

  initial begin
    int edges, busy_cnt, ndone;
    bit stable;
    logic [31:0] v;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ndig", ndigits, 1);

    run_one("zero", 32'd0);
    run_one("small", 32'd255);
    run_one("max", 32'hFFFF_FFFF);
    run_one("billion", 32'd1000000000);
    run_one("nines", 32'd999999999);

    // A second start while busy must be ignored.
    start_conv(32'd12345);
    repeat (9) step();
    bin_in = 32'd99;
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done(edges, busy_cnt, stable);
    check("ignore_latency", edges + 10, 32);
    check("ignore_bcd", bcd_out, ref_bcd(12345));
    check("ignore_ndig", ndigits, 5);
    ndone = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check("ignore_single_done", ndone, 0);

    // Back-to-back with start held high.
    bin_in = 32'd7;
    start  = 1'b1;
    step();
    bin_in = 32'd65535;
    wait_done(edges, busy_cnt, stable);
    check("b2b_first_latency", edges, 32);
    check("b2b_first_bcd", bcd_out, ref_bcd(7));
    check("b2b_first_ndig", ndigits, 1);
    step();
    start = 1'b0;
    check("b2b_rearm_busy", busy, 1);
    wait_done(edges, busy_cnt, stable);
    check("b2b_gap", edges + 1, 33);
    check("b2b_second_bcd", bcd_out, ref_bcd(65535));
    check("b2b_second_ndig", ndigits, 5);
    step();

    // Reset in the middle of a conversion.
    start_conv(32'd4000000000);
    repeat (15) step();
    rst_n = 1'b0;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bcd", bcd_out, 0);
    check("midrst_ndig", ndigits, 1);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_one("after_rst", 32'd42);

    for (int i = 0; i < 20; i++) begin
      v = $urandom;
      if (i % 4 == 1) v = v >> $urandom_range(31, 1);
      run_one("rand", v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential double-dabble converter between the operation-output mux and the display mover. It turns the 32-bit calculator result into packed decimal digits, so results can be shown in base 10 instead of hex. It converts one input bit per clock under a start/done handshake. It also reports the count of significant digits, which the display mover uses to size its scroll window.

## Interface

Parameters:
- BIN_W, default 32: width of the binary input.
- DIGITS, default 10: number of BCD digits produced. Must satisfy DIGITS ≥ ceil(BIN_W·log10 2), so 10 for 32 bits.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: request a conversion of bin_in. Sampled on the rising edge.
- bin_in, input, BIN_W: unsigned binary value. Captured on the accepting edge only.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse; bcd_out and ndigits are new this cycle.
- bcd_out, output, 4·DIGITS: packed BCD. Digit 0 (units) is in bits [3:0]; digit k is in bits [4k+3:4k].
- ndigits, output, 4: number of significant digits, 1..DIGITS. Value zero reports 1.

## Operation

- States: IDLE, SHIFT, DONE.
- **IDLE:** busy=0, done=0. If start=1, accept the request:
  - load shift register ← bin_in;
  - clear scratch BCD ← 0;
  - bit counter ← BIN_W−1;
  - go to SHIFT.
- **SHIFT:** busy=1. Each cycle, do one combined step:
  - every scratch digit ≥ 5 gets +3 (all digits in parallel, same cycle);
  - {scratch, shift register} shifts left 1; the MSB of bin_in enters the units digit.
- **SHIFT exit:** when the counter reaches 0, the final step writes straight into bcd_out. ndigits is computed from that final value, and the state goes to DONE. Otherwise the counter decrements.
- **ndigits:** 1 + the index of the highest nonzero digit; 1 if all digits are zero. Computed combinationally from the final scratch value and registered together with bcd_out.
- **DONE:** busy=0, done=1 for exactly one cycle, then IDLE. A start in DONE is accepted exactly as in IDLE, with DONE → SHIFT directly. This allows back-to-back conversions with no idle gap.
- **start while busy=1:** ignored. The conversion in flight is not affected and no request is queued.
- **bin_in:** may change freely after the accepting edge.
- **bcd_out and ndigits:** hold their last result at all times except the edge that raises done. They never expose partial scratch values.
- **Arithmetic:** the per-digit add-3 is 4-bit and cannot overflow, because an input of 5..9 maps to 8..12. The scratch register is 4·DIGITS bits. Bits shifted out of the top are discarded; the DIGITS constraint guarantees they are zero.

## Timing

- **Reset (rst_n=0 at an edge):**
  - state=IDLE, busy=0, done=0, bcd_out=0, ndigits=1, counter=0.
  - Reset takes priority over start.
  - A reset during SHIFT aborts the conversion, and no done is produced.
- **Latency:** let E0 be the edge that accepts start.
  - busy is high from E0 to E_BIN_W, i.e. BIN_W cycles.
  - done and the new bcd_out/ndigits are valid in the cycle after E_BIN_W.
  - For BIN_W=32, done occurs 32 edges after acceptance.
- **Throughput:** one conversion per BIN_W+1 cycles when start is held high continuously, because start is accepted again in DONE.
- **Output registering:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset defaults:** hold rst_n=0 for 3 cycles, then release → busy=0, done=0, bcd_out=0, ndigits=1. Pulse start with bin_in=0 → done after 32 edges, bcd_out=0x0000000000, ndigits=1.
- **Small value:** bin_in=255 → bcd_out=0x0000000255, ndigits=3. busy is high for exactly 32 cycles and done is high for exactly 1 cycle.
- **Maximum value:** bin_in=0xFFFFFFFF → bcd_out=0x4294967295, ndigits=10. Also bin_in=1000000000 → bcd_out=0x1000000000, ndigits=10.
- **Start ignored while busy:** start with 12345, then pulse start with 99 at cycle 10 → the result is 0x0000012345, ndigits=5, with a single done. The later 99 is not converted.
- **Back-to-back:** hold start=1 with bin_in=7, then change bin_in to 65535 during the first conversion → first done gives 0x0000000007 (ndigits=1). The second done arrives exactly 33 cycles after the first and gives 0x0000065535 (ndigits=5).
- **Reset mid-conversion:** assert rst_n=0 at cycle 16 of a conversion of 4000000000 → no done, outputs return to reset values. A new conversion of 42 afterwards → 0x0000000042, ndigits=2.
